i2c_reg_bank: RTL and testbench

I2C_REG_BANK -- requirements
Module: i2c_reg_bank

---
 rtl/i2c_reg_bank.sv | 171 +++++++++++++++++
 tb/tb_i2c_reg_bank.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_bank.sv
// i2c_reg_bank: byte-wide register bank behind an I2C target front end.
//
// Registers 0..RW_REGS-1 are read/write control bytes; registers
// RW_REGS..NUM_REGS-1 are read-only status bytes. The status bytes are
// captured into a snapshot on every start, so a multi-byte read returns
// values that all belong to the same instant.
// The first byte written after a start is the register pointer. Each
// later byte is written at the pointer, and the pointer then advances.
//
// Ports
//   clk        system clock
//   rst        asynchronous active-high reset
//   start      one-cycle pulse: an addressed transaction begins
//   stop       one-cycle pulse: the bus transaction ended
//   rx_byte    byte received from the controller
//   rx_valid   one-cycle pulse: rx_byte is complete
//   tx_ack     one-cycle pulse: tx_byte was shifted out and acknowledged
//   status_in  read-only register values, low byte = register RW_REGS
//   tx_byte    registered byte for the next controller read (register[ptr])
//   ctrl_regs  control register contents, low byte = register 0
//   wr_pulse   one-cycle pulse when a control register is written
//   wr_addr    register index of the last write
//   busy       high from the cycle after start until the cycle after stop
//
// NUM_REGS must be a power of two and at least 4. RW_REGS must be below
// NUM_REGS.
//
// state | meaning
// IDLE  | no transaction; rx_valid and tx_ack are ignored
// PTR   | after start; the next received byte loads the pointer
// DATA  | received bytes write at ptr, acknowledged reads advance ptr

module i2c_reg_bank #(
  parameter int NUM_REGS = 16,
  parameter int RW_REGS  = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             stop,
  input  logic [7:0]                       rx_byte,
  input  logic                             rx_valid,
  input  logic                             tx_ack,
  input  logic [8*(NUM_REGS-RW_REGS)-1:0]  status_in,
  output logic [7:0]                       tx_byte,
  output logic [8*RW_REGS-1:0]             ctrl_regs,
  output logic                             wr_pulse,
  output logic [$clog2(NUM_REGS)-1:0]      wr_addr,
  output logic                             busy
);

  localparam int AW      = $clog2(NUM_REGS);
  localparam int RO_REGS = NUM_REGS - RW_REGS;
  localparam logic [AW:0] RW_LIM = (AW+1)'(RW_REGS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PTR  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [AW-1:0]              ptr_q, ptr_d;
  logic [RW_REGS-1:0][7:0]    ctrl_q, ctrl_d;
  logic [RO_REGS-1:0][7:0]    snap_q, snap_d;
  logic [7:0]                 tx_byte_q, tx_byte_d;
  logic                       wr_pulse_q, wr_pulse_d;
  logic [AW-1:0]              wr_addr_q, wr_addr_d;
  logic                       busy_q, busy_d;

  // One event per cycle: start > stop > rx_valid > tx_ack. Lower-priority
  // pulses arriving in the same cycle are dropped.
  logic ev_start, ev_stop, ev_rx, ev_ack;
  logic ptr_is_rw;
  logic [7:0] all_regs [NUM_REGS];
  logic [7:0] rd_data;

  assign ev_start  = start;
  assign ev_stop   = stop & ~start;
  assign ev_rx     = rx_valid & ~start & ~stop;
  assign ev_ack    = tx_ack & ~start & ~stop & ~rx_valid;
  assign ptr_is_rw = ({1'b0, ptr_q} < RW_LIM);

  // Only the low AW bits of a pointer byte are used.
  generate
    if (AW < 8) begin : g_rx_hi
      logic unused_rx_hi;
      assign unused_rx_hi = ^rx_byte[7:AW];
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    ctrl_d     = ctrl_q;
    snap_d     = snap_q;
    wr_pulse_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    busy_d     = busy_q;

    if (ev_start) begin
      // Neither the pointer nor the control registers change here, so a
      // read with no pointer byte continues from the last pointer.
      state_d = PTR;
      snap_d  = status_in;
      busy_d  = 1'b1;
    end else if (ev_stop) begin
      state_d = IDLE;
      busy_d  = 1'b0;
    end else if (ev_rx) begin
      case (state_q)
        PTR: begin
          ptr_d   = rx_byte[AW-1:0];
          state_d = DATA;
        end
        DATA: begin
          if (ptr_is_rw) begin
            for (int i = 0; i < RW_REGS; i++) begin
              if (ptr_q == AW'(i)) ctrl_d[i] = rx_byte;
            end
            wr_pulse_d = 1'b1;
            wr_addr_d  = ptr_q;
          end
          ptr_d = ptr_q + AW'(1);
        end
        default: ;
      endcase
    end else if (ev_ack && (state_q != IDLE)) begin
      ptr_d   = ptr_q + AW'(1);
      state_d = DATA;
    end
  end

  // Flat view of the register map for the read mux.
  always_comb begin
    for (int i = 0; i < RW_REGS; i++) all_regs[i] = ctrl_q[i];
    for (int i = 0; i < RO_REGS; i++) all_regs[RW_REGS+i] = snap_q[i];
  end

  assign rd_data   = all_regs[ptr_q];
  assign tx_byte_d = rd_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      ctrl_q     <= '0;
      snap_q     <= '0;
      tx_byte_q  <= '0;
      wr_pulse_q <= 1'b0;
      wr_addr_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      ctrl_q     <= ctrl_d;
      snap_q     <= snap_d;
      tx_byte_q  <= tx_byte_d;
      wr_pulse_q <= wr_pulse_d;
      wr_addr_q  <= wr_addr_d;
      busy_q     <= busy_d;
    end
  end

  assign tx_byte   = tx_byte_q;
  assign ctrl_regs = ctrl_q;
  assign wr_pulse  = wr_pulse_q;
  assign wr_addr   = wr_addr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_reg_bank.sv
module tb_i2c_reg_bank;

  localparam int NUM_REGS = 16;
  localparam int RW_REGS  = 8;
  localparam int AW       = $clog2(NUM_REGS);

  logic                             clk;
  logic                             rst;
  logic                             start;
  logic                             stop;
  logic [7:0]                       rx_byte;
  logic                             rx_valid;
  logic                             tx_ack;
  logic [8*(NUM_REGS-RW_REGS)-1:0]  status_in;
  logic [7:0]                       tx_byte;
  logic [8*RW_REGS-1:0]             ctrl_regs;
  logic                             wr_pulse;
  logic [AW-1:0]                    wr_addr;
  logic                             busy;

  i2c_reg_bank #(.NUM_REGS(NUM_REGS), .RW_REGS(RW_REGS)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .tx_ack    (tx_ack),
    .status_in (status_in),
    .tx_byte   (tx_byte),
    .ctrl_regs (ctrl_regs),
    .wr_pulse  (wr_pulse),
    .wr_addr   (wr_addr),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_exp_t;

  wr_exp_t    wr_q[$];
  logic [7:0] rd_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: a write is presented by wr_pulse; a read byte is consumed when
  // the controller acknowledges it (a tx_ack colliding with rx_valid is
  // discarded by the design, so it carries no read).
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_pulse) begin
        if (wr_q.size() == 0) begin
          check("unexpected_wr_pulse", {60'd0, wr_addr}, 64'hFFFF);
        end else begin
          wr_exp_t e;
          e = wr_q.pop_front();
          check("wr_addr", {60'd0, wr_addr}, {60'd0, e.addr});
          check("wr_data", {56'd0, ctrl_regs[8*e.addr +: 8]}, {56'd0, e.data});
        end
      end
      if (tx_ack && !rx_valid && !start && !stop) begin
        if (rd_q.size() == 0) begin
          check("unexpected_read", {56'd0, tx_byte}, 64'hFFFF);
        end else begin
          logic [7:0] r;
          r = rd_q.pop_front();
          check("tx_byte", {56'd0, tx_byte}, {56'd0, r});
        end
      end
    end
  end

  task automatic pulse(input logic s, input logic p, input logic rv,
                       input logic ta, input logic [7:0] b);
    @(posedge clk); #1;
    start = s; stop = p; rx_valid = rv; tx_ack = ta; rx_byte = b;
    @(posedge clk); #1;
    start = 0; stop = 0; rx_valid = 0; tx_ack = 0; rx_byte = 8'h00;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_start();            pulse(1, 0, 0, 0, 8'h00); endtask
  task automatic do_stop();             pulse(0, 1, 0, 0, 8'h00); endtask
  task automatic do_rx(input logic [7:0] b); pulse(0, 0, 1, 0, b); endtask
  task automatic do_read(input logic [7:0] exp);
    rd_q.push_back(exp);
    pulse(0, 0, 0, 1, 8'h00);
  endtask
  task automatic do_write(input logic [AW-1:0] a, input logic [7:0] b);
    wr_exp_t e;
    e.addr = a; e.data = b;
    wr_q.push_back(e);
    do_rx(b);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    rst = 1; start = 0; stop = 0; rx_byte = 0; rx_valid = 0; tx_ack = 0;
    // reg15..reg8
    status_in = {8'hFF, 8'hEE, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h77, 8'h88};
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx_byte",  {56'd0, tx_byte}, 64'h0);
    check("reset_ctrl",     ctrl_regs, 64'h0);
    check("reset_wr_pulse", {63'd0, wr_pulse}, 64'h0);
    check("reset_wr_addr",  {60'd0, wr_addr}, 64'h0);
    check("reset_busy",     {63'd0, busy}, 64'h0);
    @(negedge clk); rst = 0;

    // Write burst: pointer 2, then two data bytes.
    do_start();
    check("busy_after_start", {63'd0, busy}, 64'h1);
    do_rx(8'h02);
    do_write(4'd2, 8'hA5);
    do_write(4'd3, 8'h3C);
    do_stop();
    check("busy_after_stop", {63'd0, busy}, 64'h0);
    check("burst_reg2", {56'd0, ctrl_regs[23:16]}, 64'hA5);
    check("burst_reg3", {56'd0, ctrl_regs[31:24]}, 64'h3C);
    // ptr persisted at 4: read reg4 with no pointer byte, then write reg5.
    do_start();
    do_read(8'h00);
    do_write(4'd5, 8'h5A);
    do_stop();

    // Pointer then repeated-start read of status.
    do_start();
    do_rx(8'h09);
    do_start();
    do_read(8'h77);
    do_read(8'hAA);
    do_read(8'hBB);
    do_stop();

    // Read-only byte at 15 is skipped, pointer wraps to 0.
    do_start();
    do_rx(8'h0F);
    do_rx(8'h11);
    do_write(4'd0, 8'h22);
    do_read(8'h00);
    do_read(8'hA5);
    do_stop();
    check("wrap_ctrl", ctrl_regs, 64'h0000_5A00_3CA5_0022);
    check("wr_addr_hold", {60'd0, wr_addr}, 64'h0);

    // Coherence: status changes after start are not seen by the read.
    do_start();
    do_rx(8'h08);
    do_start();
    status_in = {8{8'h11}};
    do_read(8'h88);
    do_read(8'h77);
    do_read(8'hAA);
    do_read(8'hBB);
    do_stop();

    // Collisions: start+rx drops the byte; rx+ack advances ptr once.
    pulse(1, 0, 1, 0, 8'h03);
    do_rx(8'h06);
    begin
      wr_exp_t e;
      e.addr = 4'd6; e.data = 8'h99;
      wr_q.push_back(e);
    end
    pulse(0, 0, 1, 1, 8'h99);
    do_read(8'h00);
    do_read(8'h11);
    do_stop();
    check("collide_ctrl", ctrl_regs, 64'h0099_5A00_3CA5_0022);

    // Async reset in the middle of a write burst.
    do_start();
    do_rx(8'h04);
    do_write(4'd4, 8'h44);
    @(negedge clk); #2;
    rst = 1;
    #1;
    check("arst_tx_byte",  {56'd0, tx_byte}, 64'h0);
    check("arst_ctrl",     ctrl_regs, 64'h0);
    check("arst_wr_addr",  {60'd0, wr_addr}, 64'h0);
    check("arst_busy",     {63'd0, busy}, 64'h0);
    check("arst_wr_pulse", {63'd0, wr_pulse}, 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 0;
    do_rx(8'h55);
    do_rx(8'h66);
    check("post_rst_ctrl", ctrl_regs, 64'h0);
    check("post_rst_busy", {63'd0, busy}, 64'h0);

    repeat (3) @(posedge clk);
    #1;
    check("wr_queue_empty", 64'(wr_q.size()), 64'h0);
    check("rd_queue_empty", 64'(rd_q.size()), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
